// File: rtl/value_input_ctrl.sv
// Button front end for the 3-digit display: sync, debounce and edge-detect four buttons,
// then keep a bounded 8-bit count and a display-enable flag. Optional macro: COUNT_WRAP_EN.
module value_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STEP            = 1,
  parameter int unsigned MAX_VALUE       = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_clr,
  input  logic       btn_disp,
  output logic [7:0] value,
  output logic       enable,
  output logic       evt
);

  localparam int          NBTN     = 4;
  localparam int          B_UP     = 0;
  localparam int          B_DOWN   = 1;
  localparam int          B_CLR    = 2;
  localparam int          B_DISP   = 3;
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [8:0]  STEP9    = 9'(STEP);
  localparam logic [8:0]  MAX9     = 9'(MAX_VALUE);
  localparam logic [8:0]  RANGE9   = 9'(MAX_VALUE + 1);

  logic [NBTN-1:0] raw, sync1, sync2, db, armed, flip, press;
  logic [1:0]      sync_vld;
  logic [15:0]     cnt [NBTN];

  assign raw = {btn_disp, btn_clr, btn_down, btn_up};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      sync_vld <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  // A flip happens on the last cycle of a full mismatch window.
  always_comb begin
    for (int i = 0; i < NBTN; i++)
      flip[i] = (sync2[i] != db[i]) && (cnt[i] == CNT_LAST);
  end

  // A button only becomes armed once it has been seen released after reset,
  // so a button held through reset never produces a press.
  assign press = flip & sync2 & armed;

  // NOTE: the debounce counters are a handful of flops, not a RAM, so they are reset like any register.
  always_ff @(posedge clk) begin
    if (rst) begin
      db    <= '0;
      armed <= '0;
      for (int i = 0; i < NBTN; i++) cnt[i] <= '0;
    end else begin
      armed <= armed | (~sync2 & {NBTN{sync_vld[1]}});
      for (int i = 0; i < NBTN; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (flip[i]) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  logic [8:0] up_sum, dn_diff;
  logic [7:0] value_nxt;
  logic       enable_nxt;

  // NOTE: every always_comb output gets a default first so no branch can infer a latch.
  always_comb begin
    up_sum     = {1'b0, value} + STEP9;
    dn_diff    = {1'b0, value} - STEP9;
    value_nxt  = value;
    enable_nxt = enable ^ press[B_DISP];
    if (press[B_CLR]) begin
      value_nxt = '0;
    end else if (press[B_UP] && press[B_DOWN]) begin
      value_nxt = value;
    end else if (press[B_UP]) begin
      if (up_sum > MAX9)
`ifdef COUNT_WRAP_EN
        value_nxt = 8'(up_sum - RANGE9);
`else
        value_nxt = MAX9[7:0];
`endif
      else
        value_nxt = up_sum[7:0];
    end else if (press[B_DOWN]) begin
      if ({1'b0, value} < STEP9)
`ifdef COUNT_WRAP_EN
        value_nxt = 8'({1'b0, value} + RANGE9 - STEP9);
`else
        value_nxt = '0;
`endif
      else
        value_nxt = dn_diff[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value  <= '0;
      enable <= 1'b1;
      evt    <= 1'b0;
    end else begin
      value  <= value_nxt;
      enable <= enable_nxt;
      evt    <= (value_nxt != value) || (enable_nxt != enable);
    end
  end

endmodule

// File: tb/tb_value_input_ctrl.sv
// Directed bench for value_input_ctrl with DEBOUNCE_CYCLES=4, STEP=1, MAX_VALUE=255.
module tb_value_input_ctrl;

  localparam int D = 4;
`ifdef COUNT_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [3:0] M_UP   = 4'b0001;
  localparam logic [3:0] M_DOWN = 4'b0010;
  localparam logic [3:0] M_CLR  = 4'b0100;
  localparam logic [3:0] M_DISP = 4'b1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_clr = 1'b0, btn_disp = 1'b0;
  logic [7:0] value;
  logic       enable, evt;
  int         errors = 0;
  int         checks = 0;

  value_input_ctrl #(.DEBOUNCE_CYCLES(D), .STEP(1), .MAX_VALUE(255)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .btn_clr(btn_clr), .btn_disp(btn_disp),
    .value(value), .enable(enable), .evt(evt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] m);
    {btn_disp, btn_clr, btn_down, btn_up} = m;
  endtask

  task automatic press_raw(input logic [3:0] m);
    drive(m);
    tick(D + 2);
    drive(4'b0000);
    tick(D + 3);
  endtask

  // Raw edge just after an edge; outputs must update exactly D+2 edges later.
  task automatic press_chk(input logic [3:0] m, input logic [7:0] ev, input logic een,
                           input logic eevt, input string tag);
    drive(m);
    tick(D + 1);
    check({tag, "_early_evt"}, 32'(evt), 32'd0);
    tick(1);
    check({tag, "_value"}, 32'(value), 32'(ev));
    check({tag, "_enable"}, 32'(enable), 32'(een));
    check({tag, "_evt"}, 32'(evt), 32'(eevt));
    tick(1);
    check({tag, "_evt_after"}, 32'(evt), 32'd0);
    drive(4'b0000);
    tick(D + 3);
    check({tag, "_hold"}, 32'(value), 32'(ev));
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_value", 32'(value), 32'd0);
    check("rst_enable", 32'(enable), 32'd1);
    check("rst_evt", 32'(evt), 32'd0);
    rst = 1'b0;
    tick(3);

    // Held button: one increment after 6 cycles, nothing more while held
    drive(M_UP);
    tick(D + 1);
    check("hold_early_value", 32'(value), 32'd0);
    tick(1);
    check("hold_value", 32'(value), 32'd1);
    check("hold_evt", 32'(evt), 32'd1);
    tick(1);
    check("hold_evt_after", 32'(evt), 32'd0);
    tick(100);
    check("hold_100_value", 32'(value), 32'd1);
    check("hold_100_evt", 32'(evt), 32'd0);
    drive(4'b0000);
    tick(D + 3);
    check("hold_release_value", 32'(value), 32'd1);

    // Bouncing press: 2-cycle pulses are rejected, final stable rise counts once
    drive(M_UP); tick(2); drive(4'b0000); tick(2);
    drive(M_UP); tick(2); drive(4'b0000); tick(2);
    check("bounce_no_press", 32'(value), 32'd1);
    press_chk(M_UP, 8'd2, 1'b1, 1'b1, "bounce");

    // Climb to 254, then test the upper bound
    for (int i = 0; i < 252; i++) press_raw(M_UP);
    check("reach_254", 32'(value), 32'd254);
    press_chk(M_UP, 8'd255, 1'b1, 1'b1, "top1");
    press_chk(M_UP, WRAP ? 8'd0 : 8'd255, 1'b1, WRAP, "top2");
    press_chk(M_UP, WRAP ? 8'd1 : 8'd255, 1'b1, WRAP, "top3");

    // Clear, clear at zero, down at zero
    press_chk(M_CLR, 8'd0, 1'b1, 1'b1, "clr");
    press_chk(M_CLR, 8'd0, 1'b1, 1'b0, "clr_at0");
    press_chk(M_DOWN, WRAP ? 8'd255 : 8'd0, 1'b1, WRAP, "down_at0");
    press_chk(M_CLR, 8'd0, 1'b1, WRAP, "clr_norm");

    // Ordinary down, then priority cases at value 5
    for (int i = 0; i < 6; i++) press_raw(M_UP);
    press_chk(M_DOWN, 8'd5, 1'b1, 1'b1, "down6");
    press_chk(M_UP | M_DOWN, 8'd5, 1'b1, 1'b0, "up_down");
    press_chk(M_CLR | M_UP, 8'd0, 1'b1, 1'b1, "clr_up");

    // Display toggle, alone and together with a value update
    press_chk(M_DISP, 8'd0, 1'b0, 1'b1, "disp1");
    press_chk(M_DISP, 8'd0, 1'b1, 1'b1, "disp2");
    press_chk(M_DISP | M_UP, 8'd1, 1'b0, 1'b1, "disp_up");

    // Reset in the middle of a debounce window with down held at value 7
    for (int i = 0; i < 6; i++) press_raw(M_UP);
    check("reach_7", 32'(value), 32'd7);
    drive(M_DOWN);
    tick(2);
    rst = 1'b1;
    tick(1);
    check("midrst_value", 32'(value), 32'd0);
    check("midrst_enable", 32'(enable), 32'd1);
    check("midrst_evt", 32'(evt), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(20);
    check("held_down_value", 32'(value), 32'd0);
    check("held_down_evt", 32'(evt), 32'd0);
    drive(4'b0000);
    tick(D + 3);

    // Up held through reset must not count until released and pressed again
    drive(M_UP);
    tick(D + 3);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(20);
    check("held_up_no_press", 32'(value), 32'd0);
    drive(4'b0000);
    tick(D + 3);
    check("held_up_release", 32'(value), 32'd0);
    press_chk(M_UP, 8'd1, 1'b1, 1'b1, "repress_up");
    press_chk(M_DOWN, 8'd0, 1'b1, 1'b1, "repress_down");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
